// File: rtl/count_display_driver_pkg.sv
// Shared types for the count display driver: segment
// patterns, scan-state encoding and anode patterns.
package count_display_driver_pkg;

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } scan_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [3:0] AN_RESET  = 4'b1110;

  // {g,f,e,d,c,b,a}, active-low
  function automatic logic [6:0] seg_pattern(
    input logic [3:0] v
  );
    logic [6:0] p;
    p = SEG_BLANK;
    unique case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] anode_of(
    input scan_t s
  );
    logic [3:0] a;
    a = 4'b1110;
    unique case (s)
      DIG0: a = 4'b1110;
      DIG1: a = 4'b1101;
      DIG2: a = 4'b1011;
      DIG3: a = 4'b0111;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/count_display_driver_seg7_decode.sv
// Combinational 4-bit value to active-low seven-segment
// pattern; blank flag or values above 9 give all-off.
module seg7_decode
  import count_display_driver_pkg::*;
(
  input  logic [3:0] val,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = seg_pattern(val);
  end

endmodule

// File: rtl/count_display_driver.sv
// Synchronises a 4-bit count, counts 15->0 wraps in BCD and
// scans both on a 4-digit display. Option: BLANK_LEADING_ZERO_EN.
module count_display_driver
  import count_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter int SAMPLE_STABLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count_in,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       wrap_pulse,
  output logic [7:0] wrap_bcd
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int SW = $clog2(SAMPLE_STABLE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] RUN_MAX  = SW'(SAMPLE_STABLE);

  logic [3:0]    s1, s2, last, stable;
  logic [SW-1:0] run, run_next;
  logic          accept, is_wrap;
  logic [PW-1:0] pre;
  logic          tick;
  scan_t         state_q, state_d;
  logic [3:0]    dig_val;
  logic          dig_blank;
  logic [6:0]    seg_d;
  logic [3:0]    bcd_ones, bcd_tens;

  // run_next counts how long s2 has held its current value
  always_comb begin
    run_next = SW'(1);
    if (s2 == last) begin
      run_next = (run < RUN_MAX) ? run + SW'(1) : run;
    end
  end

  assign accept  = (s2 != stable) && (run_next >= RUN_MAX);
  assign is_wrap = accept && (stable == 4'hF) && (s2 == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= 4'h0;
      s2     <= 4'h0;
      last   <= 4'h0;
      stable <= 4'h0;
      run    <= '0;
    end else begin
      s1   <= count_in;
      s2   <= s1;
      last <= s2;
      if (s2 == stable || accept) run <= '0;
      else                        run <= run_next;
      if (accept) stable <= s2;
    end
  end

  always_comb begin
    bcd_ones = wrap_bcd[3:0] + 4'd1;
    bcd_tens = wrap_bcd[7:4];
    if (wrap_bcd[3:0] == 4'd9) begin
      bcd_ones = 4'd0;
      bcd_tens = (wrap_bcd[7:4] == 4'd9) ? 4'd0
                                         : wrap_bcd[7:4] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_pulse <= 1'b0;
      wrap_bcd   <= 8'h00;
    end else begin
      wrap_pulse <= is_wrap;
      if (is_wrap) wrap_bcd <= {bcd_tens, bcd_ones};
    end
  end

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (rst)       pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= DIG0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      unique case (state_q)
        DIG0: state_d = DIG1;
        DIG1: state_d = DIG2;
        DIG2: state_d = DIG3;
        DIG3: state_d = DIG0;
      endcase
    end
  end

  always_comb begin
    dig_val   = 4'h0;
    dig_blank = 1'b0;
    unique case (state_q)
      DIG0: dig_val = (stable >= 4'd10) ? stable - 4'd10 : stable;
      DIG1: begin
        dig_val = {3'b000, stable >= 4'd10};
`ifdef BLANK_LEADING_ZERO_EN
        dig_blank = (stable < 4'd10);
`endif
      end
      DIG2: dig_val = wrap_bcd[3:0];
      DIG3: begin
        dig_val = wrap_bcd[7:4];
`ifdef BLANK_LEADING_ZERO_EN
        dig_blank = (wrap_bcd[7:4] == 4'd0);
`endif
      end
    endcase
  end

  seg7_decode u_dec (
    .val   (dig_val),
    .blank (dig_blank),
    .seg   (seg_d)
  );

  // Outputs follow state_q one cycle later; seg refreshes every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= SEG_ZERO;
      an  <= AN_RESET;
      dp  <= 1'b1;
    end else begin
      seg <= seg_d;
      an  <= anode_of(state_q);
      dp  <= (state_q != DIG2);
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Directed bench for count_display_driver with
// REFRESH_DIV=4 and SAMPLE_STABLE=2.
module tb_count_display_driver;

  logic       clk;
  logic       rst;
  logic [3:0] count_in;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       wrap_pulse;
  logic [7:0] wrap_bcd;

  int total = 0;
  int bad   = 0;
  int npulse = 0;
  int base;
  bit found;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
`ifdef BLANK_LEADING_ZERO_EN
  localparam logic [6:0] SLZ = 7'h7F;
`else
  localparam logic [6:0] SLZ = 7'b1000000;
`endif

  count_display_driver #(
    .REFRESH_DIV   (4),
    .SAMPLE_STABLE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .count_in   (count_in),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .wrap_pulse (wrap_pulse),
    .wrap_bcd   (wrap_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (wrap_pulse) npulse++;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_an(input logic [3:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      step(1);
      if (an == a) ok = 1'b1;
    end
  endtask

  task automatic do_wrap;
    count_in = 4'hF;
    step(6);
    count_in = 4'h0;
    step(6);
  endtask

  initial begin
    rst = 1'b1;
    count_in = 4'h0;
    step(3);
    chk("rst_an", 32'(an), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(S0));
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_wp", 32'(wrap_pulse), 32'd0);
    chk("rst_bcd", 32'(wrap_bcd), 32'h00);

    rst = 1'b0;
    wait_an(4'b1101, found);
    chk("scan_d1_found", 32'(found), 32'd1);
    chk("scan_d1_seg", 32'(seg), 32'(SLZ));
    step(3);
    chk("scan_d1_hold", 32'(an), 32'(4'b1101));
    step(1);
    chk("scan_d2_an", 32'(an), 32'(4'b1011));
    chk("scan_d2_seg", 32'(seg), 32'(S0));
    chk("scan_d2_dp", 32'(dp), 32'd0);
    step(4);
    chk("scan_d3_an", 32'(an), 32'(4'b0111));
    chk("scan_d3_seg", 32'(seg), 32'(SLZ));
    chk("scan_d3_dp", 32'(dp), 32'd1);
    step(4);
    chk("scan_d0_an", 32'(an), 32'(4'b1110));
    chk("scan_d0_seg", 32'(seg), 32'(S0));

    base = npulse;
    count_in = 4'd9;
    step(10);
    count_in = 4'd12;
    step(4);
    wait_an(4'b1110, found);
    chk("c12_d0_found", 32'(found), 32'd1);
    chk("c12_d0_seg", 32'(seg), 32'(S2));
    wait_an(4'b1101, found);
    chk("c12_d1_found", 32'(found), 32'd1);
    chk("c12_d1_seg", 32'(seg), 32'(S1));
    chk("c12_nowrap", 32'(npulse - base), 32'd0);

    count_in = 4'hF;
    step(10);
    base = npulse;
    count_in = 4'h0;
    step(3);
    chk("wrap_e3", 32'(wrap_pulse), 32'd0);
    step(1);
    chk("wrap_e4", 32'(wrap_pulse), 32'd1);
    chk("wrap_bcd1", 32'(wrap_bcd), 32'h01);
    step(1);
    chk("wrap_e5", 32'(wrap_pulse), 32'd0);
    chk("wrap_once", 32'(npulse - base), 32'd1);
    wait_an(4'b1011, found);
    chk("wrap_d2_found", 32'(found), 32'd1);
    chk("wrap_d2_seg", 32'(seg), 32'(S1));

    base = npulse;
    count_in = 4'd7;
    step(10);
    count_in = 4'd0;
    step(10);
    chk("c7to0_nowrap", 32'(npulse - base), 32'd0);
    chk("c7to0_bcd", 32'(wrap_bcd), 32'h01);

    count_in = 4'hF;
    step(10);
    base = npulse;
    count_in = 4'h0;
    step(1);
    count_in = 4'hF;
    step(10);
    chk("glitch_nowrap", 32'(npulse - base), 32'd0);
    chk("glitch_bcd", 32'(wrap_bcd), 32'h01);

    rst = 1'b1;
    count_in = 4'h0;
    step(2);
    rst = 1'b0;
    step(2);
    base = npulse;
    for (int i = 1; i <= 100; i++) begin
      do_wrap();
      if (i == 9)   chk("w100_09", 32'(wrap_bcd), 32'h09);
      if (i == 10)  chk("w100_10", 32'(wrap_bcd), 32'h10);
      if (i == 99)  chk("w100_99", 32'(wrap_bcd), 32'h99);
      if (i == 100) chk("w100_00", 32'(wrap_bcd), 32'h00);
    end
    chk("w100_pulses", 32'(npulse - base), 32'd100);

    for (int i = 0; i < 37; i++) do_wrap();
    chk("mid_bcd37", 32'(wrap_bcd), 32'h37);
    count_in = 4'd5;
    step(8);
    wait_an(4'b1011, found);
    chk("mid_found", 32'(found), 32'd1);
    step(1);
    rst = 1'b1;
    step(1);
    chk("mid_an", 32'(an), 32'(4'b1110));
    chk("mid_bcd", 32'(wrap_bcd), 32'h00);
    chk("mid_seg", 32'(seg), 32'(S0));
    chk("mid_wp", 32'(wrap_pulse), 32'd0);
    chk("mid_dp", 32'(dp), 32'd1);
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit binary counter output.
- Shows the live count (0–15) in decimal on digits 1:0 of a 4-digit multiplexed common-anode seven-segment display.
- Shows the number of counter wrap-arounds (15→0, BCD 00–99) on digits 3:2.
- Runs on the board clock; the counter value arrives from the slower divided-clock domain and is synchronised and stability-filtered here.

Parameters:
- REFRESH_DIV, 100000, board-clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range ≥2.
- SAMPLE_STABLE, 2, consecutive identical synchronised samples required before a new count value is accepted; legal range ≥1.

Ports:
- clk  input  1  board clock
- rst  input  1  synchronous, active-high reset
- count_in  input  4  counter value (changes on divided-clock edges, asynchronous to clk)
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- an  output  4  digit anodes, one-hot active-low, an[0] = rightmost digit
- dp  output  1  decimal point, active-low
- wrap_pulse  output  1  one-cycle high on each accepted 15→0 transition
- wrap_bcd  output  8  wrap count, {tens, ones} BCD

Behaviour:
- Clocking and reset:
  - One clock; all state updates on posedge clk; reset is synchronous, active-high, and has priority over every other event.
- Reset values:
  - seg=7'b1000000 ("0"), an=4'b1110, dp=1.
  - wrap_pulse=0, wrap_bcd=8'h00.
  - Stable count=0, sync flops=0, prescaler=0, scan state=DIG0.
- Input capture:
  - count_in passes through a 2-flop synchroniser.
  - A stability counter accepts the synchronised value as the new stable count only after SAMPLE_STABLE consecutive equal samples that differ from the current stable count.
  - Latency from a count_in change to the stable update: 2+SAMPLE_STABLE cycles.
- Wrap detection:
  - The update cycle where the previous stable value is 4'hF and the new one is 4'h0 asserts wrap_pulse for exactly one cycle.
  - In that same cycle, wrap_bcd increments in BCD: ones 9→0 carries into tens; 99→00 wraps silently.
  - Any other transition (e.g. 7→0 from a counter reset, or 15→3) is not a wrap.
  - A 15→0 caused by the counter's own reset is indistinguishable and is counted.
- Digit values:
  - DIG0 = stable count mod 10.
  - DIG1 = tens of stable count (0 or 1).
  - DIG2 = wrap ones.
  - DIG3 = wrap tens.
- Scan FSM:
  - States DIG0→DIG1→DIG2→DIG3→DIG0.
  - Advances on the prescaler terminal tick: prescaler counts 0..REFRESH_DIV-1, tick at REFRESH_DIV-1, then returns to 0.
  - seg/an are registered; they reflect the new state one cycle after the tick.
  - an is always exactly one-hot low, never two digits on.
- Mid-scan update:
  - A stable-count or wrap update during a slot appears on the next registered seg refresh of that slot (seg is recomputed every cycle from the current state), so the change is visible within one cycle.
- dp:
  - Low (lit) only while DIG2 is active, separating count from wrap field; high otherwise.
- Reset mid-operation:
  - Returns to reset values on the next edge, including wrap_bcd.
  - No wrap_pulse is issued for reset.

Optional Feature:
- Macro BLANK_LEADING_ZERO_EN.
- Defined:
  - DIG1 is blanked (seg=7'h7F) when the count is <10.
  - DIG3 is blanked when wrap tens=0.
  - an still scans all four digits; timing is unchanged.
- Undefined: all digits always show their value, including leading zeros.

Decomposition:
- Shared package:
  - Segment patterns for 0–9 and BLANK.
  - Scan-state encoding (DIG0..DIG3, 2-bit).
  - Active-low anode patterns per state.
- Sub-module seg7_decode: purely combinational 4-bit value plus blank flag → 7-bit active-low pattern; values >9 map to BLANK.
- Prescaler, synchroniser/filter, wrap logic and scan FSM remain in count_display_driver.

Test Plan (REFRESH_DIV=4, SAMPLE_STABLE=2):
- Reset then hold count_in=0 → an cycles 1110,1101,1011,0111 every 4 clocks; seg=7'b1000000 on all digits; wrap_bcd=00.
- count_in 9→12 → 4 clocks later the DIG0 slot shows "2" (7'b0100100) and the DIG1 slot shows "1" (7'b1111001); no wrap_pulse.
- count_in 15→0 → exactly one wrap_pulse, 4 clocks after the change; wrap_bcd=01; DIG2 shows "1".
- count_in 7→0 → no wrap_pulse; wrap_bcd unchanged.
- 100 wrap sequences from reset → wrap_bcd goes 09→10 at the 10th wrap and 99→00 at the 100th.
- One-cycle glitch count_in 15→0→15 → no stable update, no wrap_pulse.
- Assert rst mid-scan with wrap_bcd=37 → next edge: an=1110, wrap_bcd=00, seg="0", wrap_pulse=0.
